mor1kx_l15_responder: RTL and testbench

Behavioural L1.5 responder that terminates the core-side transducer request interface driven by the mor1kx icache/dcache arbiter.
- Accepts one request at a time with a header/request ack.
- Services loads, instruction fills and stores from a local 64-bit-word memory after a programmable latency.
- Holds the response until the requester acknowledges it.
- Used as the L1.5 stand-in for core-level simulation and FPGA bring-up without the full OpenPiton tile.

---
 rtl/mor1kx_l15_responder_pkg.sv | 35 +++
 rtl/mor1kx_l15_resp_mem.sv | 43 ++++
 rtl/mor1kx_l15_responder.sv | 209 ++++++++++++++++++++
 tb/tb_mor1kx_l15_responder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mor1kx_l15_responder_pkg.sv
// Shared L1.5 transducer definitions for the behavioural responder.
// Contents: request/return type encodings, error codes, FSM state type
// and the big-endian byte-lane helper used by the store path.
package mor1kx_l15_responder_pkg;

    localparam logic [4:0] LOAD_RQ   = 5'b00000;
    localparam logic [4:0] STORE_RQ  = 5'b00001;
    localparam logic [4:0] IMISS_RQ  = 5'b10000;

    localparam logic [3:0] LOAD_RET  = 4'h0;
    localparam logic [3:0] IFILL_RET = 4'h1;
    localparam logic [3:0] ST_ACK    = 4'h4;

    localparam logic [1:0] L15_ERR_NONE = 2'b00;
    localparam logic [1:0] L15_ERR      = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_WAIT,
        S_RESP
    } l15_state_t;

    // Lane mask for a (1 << size) byte access starting at byte offset off.
    // Bit j of the result selects byte lane j (lane 0 is bits [63:56]).
    function automatic logic [7:0] byte_lanes(input logic [2:0] off,
                                              input logic [1:0] size);
        logic [3:0]  nb;
        logic [15:0] m;
        nb = 4'd1 << size;
        m  = ((16'd1 << nb) - 16'd1) << off;
        return m[7:0];
    endfunction

endpackage

// File: rtl/mor1kx_l15_resp_mem.sv
// Local backing store for the L1.5 responder.
// Ports:
//   clk                 clock
//   wr_en/wr_idx        byte-enabled write of word wr_idx
//   wr_be/wr_data       lane enables (bit j = lane j, lane 0 = MSB byte), data
//   rd_base             base word index of the 4-word read window
//   rd_data_0..3        mem[rd_base+0..3], indices wrap modulo MEM_WORDS
// The array is named mem so a bench can reach it hierarchically for preload.
module mor1kx_l15_resp_mem #(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [7:0]    wr_be,
    input  logic [63:0]   wr_data,
    input  logic [AW-1:0] rd_base,
    output logic [63:0]   rd_data_0,
    output logic [63:0]   rd_data_1,
    output logic [63:0]   rd_data_2,
    output logic [63:0]   rd_data_3
);

    logic [63:0] mem [MEM_WORDS];
    logic [63:0] wr_mask;

    assign wr_mask = {{8{wr_be[0]}}, {8{wr_be[1]}}, {8{wr_be[2]}}, {8{wr_be[3]}},
                      {8{wr_be[4]}}, {8{wr_be[5]}}, {8{wr_be[6]}}, {8{wr_be[7]}}};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= (mem[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    // MEM_WORDS is a power of two, so AW-bit addition wraps for free.
    assign rd_data_0 = mem[rd_base];
    assign rd_data_1 = mem[rd_base + AW'(1)];
    assign rd_data_2 = mem[rd_base + AW'(2)];
    assign rd_data_3 = mem[rd_base + AW'(3)];

endmodule

// File: rtl/mor1kx_l15_responder.sv
// Behavioural L1.5 responder terminating the mor1kx transducer interface.
// Accepts one request at a time (header_ack/ack for one cycle), services
// loads, instruction fills and stores from a local 64-bit word memory after
// LATENCY wait cycles, and holds the response until transducer_l15_req_ack.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   transducer_l15_*               request side (l1rplway, data_next_entry unused)
//   l15_transducer_header_ack/ack  request accepted (ACK cycle)
//   l15_transducer_val             response valid
//   l15_transducer_returntype      LOAD_RET / IFILL_RET / ST_ACK
//   l15_transducer_error           00 ok, 11 error
//   l15_transducer_noncacheable    captured nc
//   l15_transducer_data_0..3       response data words
module mor1kx_l15_responder
    import mor1kx_l15_responder_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        transducer_l15_val,
    input  logic [4:0]  transducer_l15_rqtype,
    input  logic [3:0]  transducer_l15_amo_op,
    input  logic        transducer_l15_nc,
    input  logic [2:0]  transducer_l15_size,
    input  logic [1:0]  transducer_l15_l1rplway,
    input  logic [39:0] transducer_l15_address,
    input  logic [63:0] transducer_l15_data,
    input  logic [63:0] transducer_l15_data_next_entry,
    input  logic        transducer_l15_req_ack,
    output logic        l15_transducer_header_ack,
    output logic        l15_transducer_ack,
    output logic        l15_transducer_val,
    output logic [3:0]  l15_transducer_returntype,
    output logic [1:0]  l15_transducer_error,
    output logic        l15_transducer_noncacheable,
    output logic [63:0] l15_transducer_data_0,
    output logic [63:0] l15_transducer_data_1,
    output logic [63:0] l15_transducer_data_2,
    output logic [63:0] l15_transducer_data_3
);

    localparam int              AW        = $clog2(MEM_WORDS);
    localparam int              CW        = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [36:0]     MEM_LIMIT = 37'(MEM_WORDS);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(LATENCY);

    l15_state_t    state;
    logic [CW-1:0] cnt;

    // Request captured in IDLE; everything downstream decodes from these.
    logic [4:0]    rq_q;
    logic [3:0]    amo_q;
    logic          nc_q;
    logic [2:0]    size_q;
    logic [39:0]   addr_q;
    logic [63:0]   data_q;

    logic          is_store, is_imiss, known, aligned, req_err;
    logic          wr_en, load_resp;
    logic [AW-1:0] idx, rd_base;
    logic [7:0]    be;
    logic [63:0]   rd0, rd1, rd2, rd3;
    logic [3:0]    rt_n;
    logic [63:0]   d0_n, d1_n, d2_n, d3_n;

    logic          unused_inputs;
    assign unused_inputs = ^{transducer_l15_l1rplway, transducer_l15_data_next_entry};

    always_comb begin
        is_store = (rq_q == STORE_RQ);
        is_imiss = (rq_q == IMISS_RQ);
        known    = is_store || is_imiss || (rq_q == LOAD_RQ);

        case (size_q)
            3'd0:    aligned = 1'b1;
            3'd1:    aligned = ~addr_q[0];
            3'd2:    aligned = (addr_q[1:0] == 2'b00);
            3'd3:    aligned = (addr_q[2:0] == 3'b000);
            default: aligned = 1'b0;
        endcase

        req_err = !known || (amo_q != 4'd0) || (addr_q[39:3] >= MEM_LIMIT) || !aligned;

        idx     = addr_q[AW+2:3];
        rd_base = is_imiss ? (idx & ~AW'(3)) : idx;
        be      = byte_lanes(addr_q[2:0], size_q[1:0]);

        wr_en     = (state == S_ACK) && is_store && !req_err;
        load_resp = ((state == S_ACK) && (LATENCY == 0)) ||
                    ((state == S_WAIT) && (cnt == CNT_LAST));

        rt_n = is_store ? ST_ACK : (is_imiss ? IFILL_RET : LOAD_RET);
        d0_n = '0;
        d1_n = '0;
        d2_n = '0;
        d3_n = '0;
        if (!req_err && !is_store) begin
            d0_n = rd0;
            d1_n = rd1;
            if (is_imiss) begin
                d2_n = rd2;
                d3_n = rd3;
            end
        end
    end

    mor1kx_l15_resp_mem #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_mem (
        .clk       (clk),
        .wr_en     (wr_en),
        .wr_idx    (idx),
        .wr_be     (be),
        .wr_data   (data_q),
        .rd_base   (rd_base),
        .rd_data_0 (rd0),
        .rd_data_1 (rd1),
        .rd_data_2 (rd2),
        .rd_data_3 (rd3)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state                       <= S_IDLE;
            cnt                         <= '0;
            rq_q                        <= '0;
            amo_q                       <= '0;
            nc_q                        <= 1'b0;
            size_q                      <= '0;
            addr_q                      <= '0;
            data_q                      <= '0;
            l15_transducer_header_ack   <= 1'b0;
            l15_transducer_ack          <= 1'b0;
            l15_transducer_val          <= 1'b0;
            l15_transducer_returntype   <= '0;
            l15_transducer_error        <= '0;
            l15_transducer_noncacheable <= 1'b0;
            l15_transducer_data_0       <= '0;
            l15_transducer_data_1       <= '0;
            l15_transducer_data_2       <= '0;
            l15_transducer_data_3       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (transducer_l15_val) begin
                        rq_q                      <= transducer_l15_rqtype;
                        amo_q                     <= transducer_l15_amo_op;
                        nc_q                      <= transducer_l15_nc;
                        size_q                    <= transducer_l15_size;
                        addr_q                    <= transducer_l15_address;
                        data_q                    <= transducer_l15_data;
                        l15_transducer_header_ack <= 1'b1;
                        l15_transducer_ack        <= 1'b1;
                        state                     <= S_ACK;
                    end
                end
                S_ACK: begin
                    l15_transducer_header_ack <= 1'b0;
                    l15_transducer_ack        <= 1'b0;
                    if (LATENCY == 0) begin
                        state <= S_RESP;
                    end else begin
                        cnt   <= CW'(1);
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (transducer_l15_req_ack) begin
                        cnt                         <= '0;
                        l15_transducer_val          <= 1'b0;
                        l15_transducer_returntype   <= '0;
                        l15_transducer_error        <= '0;
                        l15_transducer_noncacheable <= 1'b0;
                        l15_transducer_data_0       <= '0;
                        l15_transducer_data_1       <= '0;
                        l15_transducer_data_2       <= '0;
                        l15_transducer_data_3       <= '0;
                        state                       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Response is sampled one cycle after the store commit at the
            // earliest, so load data always reflects prior stores.
            if (load_resp) begin
                l15_transducer_val          <= 1'b1;
                l15_transducer_returntype   <= rt_n;
                l15_transducer_error        <= req_err ? L15_ERR : L15_ERR_NONE;
                l15_transducer_noncacheable <= nc_q;
                l15_transducer_data_0       <= d0_n;
                l15_transducer_data_1       <= d1_n;
                l15_transducer_data_2       <= d2_n;
                l15_transducer_data_3       <= d3_n;
            end
        end
    end

endmodule

// File: tb/tb_mor1kx_l15_responder.sv
// Scoreboard bench: two responders (LATENCY=4 and LATENCY=0) run the same
// directed + random scenario concurrently. Drivers push the reference
// model's expected response; per-instance monitors pop and compare.
module tb_mor1kx_l15_responder;

    localparam int MW = 64;

    typedef struct packed {
        logic [4:0]  rq;
        logic [3:0]  amo;
        logic        nc;
        logic [2:0]  size;
        logic [39:0] addr;
        logic [63:0] data;
    } req_t;

    typedef struct packed {
        logic [3:0]  rt;
        logic [1:0]  err;
        logic        nc;
        logic [63:0] d0;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [63:0] d3;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic req_t mk(input logic [4:0] rq, input logic [3:0] amo, input logic nc,
                                input logic [2:0] size, input logic [39:0] addr,
                                input logic [63:0] data);
        req_t r;
        r.rq = rq; r.amo = amo; r.nc = nc; r.size = size; r.addr = addr; r.data = data;
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 4 : 0;

        logic        rst;
        logic        t_val;
        logic [4:0]  t_rq;
        logic [3:0]  t_amo;
        logic        t_nc;
        logic [2:0]  t_size;
        logic [1:0]  t_way;
        logic [39:0] t_addr;
        logic [63:0] t_data;
        logic [63:0] t_next;
        logic        t_req_ack;
        logic        hdr_ack, ack, r_val, r_nc;
        logic [3:0]  r_rt;
        logic [1:0]  r_err;
        logic [63:0] r_d0, r_d1, r_d2, r_d3;
        bit          done = 1'b0;

        resp_t       exp_q[$];
        logic [63:0] mem_m [MW];

        mor1kx_l15_responder #(
            .MEM_WORDS (MW),
            .LATENCY   (LAT)
        ) u_dut (
            .clk                            (clk),
            .rst                            (rst),
            .transducer_l15_val             (t_val),
            .transducer_l15_rqtype          (t_rq),
            .transducer_l15_amo_op          (t_amo),
            .transducer_l15_nc              (t_nc),
            .transducer_l15_size            (t_size),
            .transducer_l15_l1rplway        (t_way),
            .transducer_l15_address         (t_addr),
            .transducer_l15_data            (t_data),
            .transducer_l15_data_next_entry (t_next),
            .transducer_l15_req_ack         (t_req_ack),
            .l15_transducer_header_ack      (hdr_ack),
            .l15_transducer_ack             (ack),
            .l15_transducer_val             (r_val),
            .l15_transducer_returntype      (r_rt),
            .l15_transducer_error           (r_err),
            .l15_transducer_noncacheable    (r_nc),
            .l15_transducer_data_0          (r_d0),
            .l15_transducer_data_1          (r_d1),
            .l15_transducer_data_2          (r_d2),
            .l15_transducer_data_3          (r_d3)
        );

        task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
            check($sformatf("lat%0d %s", LAT, name), act, exp);
        endtask

        // Reference model: the response each request must produce, with
        // store side effects applied to the model memory.
        function automatic resp_t model(input req_t r);
            resp_t       e;
            bit          err;
            int unsigned idx, base, off, nb;
            logic [63:0] m;
            e    = '0;
            e.nc = r.nc;
            e.rt = (r.rq == 5'b00001) ? 4'h4 : (r.rq == 5'b10000) ? 4'h1 : 4'h0;
            err  = !(r.rq == 5'b00000 || r.rq == 5'b00001 || r.rq == 5'b10000) ||
                   (r.amo != 0) || (r.size > 3) || ((r.addr >> 3) >= 40'(MW));
            if (!err) err = (r.addr % (40'd1 << r.size)) != 0;
            if (err) begin
                e.err = 2'b11;
                return e;
            end
            idx = int'(r.addr >> 3);
            if (r.rq == 5'b00000) begin
                e.d0 = mem_m[idx];
                e.d1 = mem_m[(idx + 1) % MW];
            end else if (r.rq == 5'b10000) begin
                base = (idx / 4) * 4;
                e.d0 = mem_m[base];
                e.d1 = mem_m[base + 1];
                e.d2 = mem_m[base + 2];
                e.d3 = mem_m[base + 3];
            end else begin
                off = int'(r.addr % 8);
                nb  = 1 << r.size;
                for (int unsigned b = off; b < off + nb; b++) begin
                    m = 64'hFF << (56 - 8 * b);
                    mem_m[idx] = (mem_m[idx] & ~m) | (r.data & m);
                end
            end
            return e;
        endfunction

        task automatic drive(input req_t r);
            t_val  = 1'b1;
            t_rq   = r.rq;
            t_amo  = r.amo;
            t_nc   = r.nc;
            t_size = r.size;
            t_addr = r.addr;
            t_data = r.data;
            t_way  = 2'($urandom);
            t_next = {$urandom, $urandom};
        endtask

        task automatic do_req(input req_t r, input int hold, input bit already,
                              input bit have_next, input req_t nxt);
            int n;
            bit got;
            exp_q.push_back(model(r));
            if (!already) begin
                @(posedge clk); #1;
                drive(r);
            end
            n = 0; got = 0;
            while (n < 5) begin
                @(posedge clk); #1;
                n++;
                if (ack) begin got = 1; break; end
            end
            t_val = 1'b0;
            chk("ack_latency", 64'(n), got ? 64'd1 : 64'd99);
            if (!got) return;
            chk("header_ack", 64'(hdr_ack), 64'd1);
            n = 0;
            while (!r_val && n < LAT + 10) begin
                @(posedge clk); #1;
                n++;
            end
            chk("resp_latency", 64'(n), 64'(LAT + 1));
            if (!r_val) return;
            if (have_next) drive(nxt);
            repeat (hold) begin
                @(posedge clk); #1;
                if (have_next) chk("no_ack_in_resp", 64'(ack), 64'd0);
            end
            t_req_ack = 1'b1;
            @(posedge clk); #1;
            t_req_ack = 1'b0;
            chk("val_cleared", 64'(r_val), 64'd0);
            chk("data_cleared", r_d0 | r_d1 | r_d2 | r_d3, 64'd0);
            if (have_next) chk("no_ack_idle_cycle", 64'(ack), 64'd0);
        endtask

        task automatic req(input req_t r);
            do_req(r, 0, 1'b0, 1'b0, '0);
        endtask

        // Monitor: compare on the first cycle of each response, then check
        // that it stays stable until it is released.
        initial begin
            bit    prev;
            resp_t cur, cap, e;
            prev = 0;
            cap  = '0;
            forever begin
                @(negedge clk);
                cur.rt = r_rt; cur.err = r_err; cur.nc = r_nc;
                cur.d0 = r_d0; cur.d1 = r_d1; cur.d2 = r_d2; cur.d3 = r_d3;
                if (rst) begin
                    prev = 0;
                end else if (r_val && !prev) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_response", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("returntype", 64'(cur.rt), 64'(e.rt));
                        chk("error", 64'(cur.err), 64'(e.err));
                        chk("noncacheable", 64'(cur.nc), 64'(e.nc));
                        chk("data_0", cur.d0, e.d0);
                        chk("data_1", cur.d1, e.d1);
                        chk("data_2", cur.d2, e.d2);
                        chk("data_3", cur.d3, e.d3);
                    end
                    cap  = cur;
                    prev = 1;
                end else if (r_val) begin
                    chk("resp_stable", 64'(cur == cap), 64'd1);
                end else begin
                    prev = 0;
                end
            end
        end

        initial begin
            req_t        r, nxt;
            int unsigned w, sz, off;
            logic [4:0]  rq;
            t_req_ack = 1'b0;
            t_val = 1'b0; t_rq = '0; t_amo = '0; t_nc = 1'b0; t_size = '0;
            t_way = '0; t_addr = '0; t_data = '0; t_next = '0;

            // Reset held with a request pending: nothing may respond.
            r = mk(5'b00001, 4'd0, 1'b0, 3'd3, 40'h0, 64'hA5A5_0000_5A5A_0000 ^ 64'(g));
            rst = 1'b1;
            drive(r);
            repeat (2) begin
                @(posedge clk); #1;
                chk("rst_ack", 64'({hdr_ack, ack}), 64'd0);
                chk("rst_val", 64'(r_val), 64'd0);
                chk("rst_outs", 64'({r_rt, r_err, r_nc}) | r_d0 | r_d1 | r_d2 | r_d3, 64'd0);
            end
            rst = 1'b0;
            do_req(r, 0, 1'b1, 1'b0, '0);

            // Initialise the region the rest of the run touches.
            for (w = 1; w <= 16; w++) req(mk(5'b00001, 0, 0, 3, 40'(w * 8), {$urandom, $urandom}));
            for (w = MW - 4; w < MW; w++) req(mk(5'b00001, 0, 0, 3, 40'(w * 8), {$urandom, $urandom}));

            // Store / load / byte store / misaligned.
            req(mk(5'b00001, 0, 0, 3, 40'h20, 64'h0));
            req(mk(5'b00001, 0, 0, 3, 40'h20, 64'h1122334455667788));
            req(mk(5'b00000, 0, 0, 3, 40'h20, 64'h0));
            req(mk(5'b00001, 0, 0, 0, 40'h23, 64'h000000AB_00000000));
            req(mk(5'b00000, 0, 0, 3, 40'h20, 64'h0));
            req(mk(5'b00001, 0, 0, 2, 40'h22, 64'hFFFF_FFFF_FFFF_FFFF));
            req(mk(5'b00000, 0, 0, 3, 40'h20, 64'h0));

            // Instruction fill of line 8..11 with nc echoed.
            for (w = 0; w < 4; w++) req(mk(5'b00001, 0, 0, 3, 40'((8 + w) * 8), 64'(w + 1)));
            req(mk(5'b10000, 0, 1, 3, 40'h50, 64'h0));

            // Response held 5 cycles with the next request already valid.
            nxt = mk(5'b00000, 0, 1, 3, 40'h48, 64'h0);
            do_req(mk(5'b00000, 0, 0, 3, 40'h40, 64'h0), 5, 1'b0, 1'b1, nxt);
            do_req(nxt, 0, 1'b1, 1'b0, '0);

            // Error and boundary cases.
            req(mk(5'b00010, 0, 0, 3, 40'h8, 64'h0));
            req(mk(5'b00000, 0, 0, 3, 40'(MW * 8), 64'h0));
            req(mk(5'b00000, 0, 0, 3, 40'((MW - 1) * 8), 64'h0));
            req(mk(5'b00000, 0, 0, 4, 40'h10, 64'h0));
            req(mk(5'b00001, 4'd3, 0, 3, 40'h10, 64'h1));
            req(mk(5'b10000, 0, 0, 3, 40'(MW * 8 + 8), 64'h0));
            req(mk(5'b00000, 0, 0, 3, 40'h10, 64'h0));

            // Randomised traffic within the initialised region.
            for (int i = 0; i < 40; i++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: rq = 5'b00000;
                    3, 4, 5: rq = 5'b00001;
                    6, 7:    rq = 5'b10000;
                    default: rq = 5'($urandom);
                endcase
                w   = ($urandom_range(0, 3) == 0) ? $urandom_range(MW - 4, MW - 1) : $urandom_range(0, 15);
                sz  = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
                off = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7)
                                                  : ($urandom_range(0, 7) >> (sz > 3 ? 0 : sz)) << (sz > 3 ? 0 : sz);
                r = mk(rq, ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                       1'($urandom), 3'(sz), 40'(w * 8 + off), {$urandom, $urandom});
                if ($urandom_range(0, 19) == 0) r.addr = r.addr + 40'(MW * 8);
                do_req(r, int'($urandom_range(0, 3)), 1'b0, 1'b0, '0);
            end

            repeat (3) @(posedge clk);
            #1;
            chk("queue_drained", 64'(exp_q.size()), 64'd0);
            done = 1'b1;
        end
    end

    initial begin
        wait (g_inst[0].done && g_inst[1].done);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
